// File: rtl/dmem_ctrl.sv
// Single-port data memory behind the MEM stage. Loads take two cycles through a registered
// read, and the pipeline stalls for the first of them. Stores write by byte lane in one cycle.
module dmem_ctrl #(
  parameter int DEPTH_LOG2 = 10,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        addr_err_o,
  output logic [31:0] load_cnt_o,
  output logic [31:0] store_cnt_o
);

  localparam int          WORDS     = 1 << DEPTH_LOG2;
  localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0 : 32'hxxxx_xxxx;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_e;

  state_e                state_q;
  logic [31:0]           data_q;
  logic                  addr_err_q;
  logic [31:0]           load_cnt_q;
  logic [31:0]           store_cnt_q;

  // Power-up contents only; reset deliberately leaves the array alone.
  logic [31:0]           mem_q [WORDS] = '{default: INIT_WORD};

  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor;
  logic                  ld_go;
  logic                  st_go;
  logic [31:0]           rd_word_d;
  logic                  unused_addr_lsb;

  assign idx             = mem_addr_i[DEPTH_LOG2+1:2];
  assign oor             = |mem_addr_i[31:DEPTH_LOG2+2];
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  // Requests are only accepted from IDLE outside reset; RD_WAIT ignores the held inputs.
  assign ld_go = rst && (state_q == S_IDLE) && mem_ce_i && !mem_we_i;
  assign st_go = rst && (state_q == S_IDLE) && mem_ce_i &&  mem_we_i;

  assign rd_word_d = oor ? 32'h0 : mem_q[idx];

  assign stallreq_o  = ld_go;
  assign mem_data_o  = data_q;
  assign addr_err_o  = addr_err_q;
  assign load_cnt_o  = load_cnt_q;
  assign store_cnt_o = store_cnt_q;

  always_ff @(posedge clk) begin
    if (st_go && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_sel_i[b]) begin
          mem_q[idx][8*b +: 8] <= mem_data_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      data_q      <= 32'h0;
      addr_err_q  <= 1'b0;
      load_cnt_q  <= 32'h0;
      store_cnt_q <= 32'h0;
    end else begin
      addr_err_q <= (ld_go || st_go) && oor;
      case (state_q)
        S_IDLE: begin
          if (ld_go) begin
            data_q  <= rd_word_d;
            state_q <= S_RD_WAIT;
          end
          if (st_go) begin
            store_cnt_q <= store_cnt_q + 32'd1;
          end
        end
        S_RD_WAIT: begin
          load_cnt_q <= load_cnt_q + 32'd1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
